// File: rtl/counter7sd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter7sd_pkg
// Shared definitions for the seven-segment counter control front end.
//   - Output reset values for the pause/reverse control levels
//   - Debounce FSM state encoding
//   - Default parameter values for the control stage
// Optional build macro used elsewhere in this slice: COUNTER7SD_CTRL_LOCK_EN
// -----------------------------------------------------------------------------
package counter7sd_pkg;

    // pause is active-low for the counter: 1 = running after reset
    localparam logic PAUSE_RST   = 1'b1;
    localparam logic REVERSE_RST = 1'b0;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } db_state_t;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 50000;
    localparam int TICK_DIV_DEF        = 50000000;

endpackage : counter7sd_pkg

// File: rtl/counter7sd_ctrl_if.sv
// -----------------------------------------------------------------------------
// counter7sd_ctrl_if
// Button inputs and counter-control outputs of the control stage.
//   btn_pause, btn_reverse : raw asynchronous buttons, 1 = pressed
//   pause                  : 1 = running, 0 = paused
//   reverse                : 0 = count up, 1 = count down
//   tick                   : one-cycle count-enable pulse
// Modports:
//   master : drives the buttons, observes the controls (board / bench side)
//   slave  : the control stage itself
// -----------------------------------------------------------------------------
interface counter7sd_ctrl_if;
    logic btn_pause;
    logic btn_reverse;
    logic pause;
    logic reverse;
    logic tick;

    modport master (
        output btn_pause,
        output btn_reverse,
        input  pause,
        input  reverse,
        input  tick
    );

    modport slave (
        input  btn_pause,
        input  btn_reverse,
        output pause,
        output reverse,
        output tick
    );
endinterface : counter7sd_ctrl_if

// File: rtl/counter7sd_ctrl_debounce_cell.sv
// -----------------------------------------------------------------------------
// debounce_cell
// Synchroniser + debounce FSM + rising-edge press detector for one button.
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-low
//   btn    : raw asynchronous button, 1 = pressed
//   stable : debounced button level
//   press  : one-cycle registered pulse when stable goes 0 -> 1
// -----------------------------------------------------------------------------
module debounce_cell
    import counter7sd_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic stable,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ---------------------------------------------------------------- sync
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_x;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    sync_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= btn;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign sync_x = sync_reg[SYNC_STAGES-1];

    // ---------------------------------------------------------------- FSM
    db_state_t        state_reg,  state_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic             stable_reg, stable_next;
    logic             press_reg,  press_next;
    logic             accept;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_STABLE;
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
            press_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            stable_reg <= stable_next;
            press_reg  <= press_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        press_next  = 1'b0;
        accept      = 1'b0;

        case (state_reg)
            ST_STABLE: begin
                if (sync_x != stable_reg) begin
                    // With a one-cycle debounce the first mismatch is already
                    // enough, so PENDING is skipped entirely.
                    if (DEBOUNCE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        cnt_next   = CNT_W'(1);
                        state_next = ST_PENDING;
                    end
                end else begin
                    cnt_next = '0;
                end
            end
            ST_PENDING: begin
                if (sync_x == stable_reg) begin
                    cnt_next   = '0;
                    state_next = ST_STABLE;
                end else if (cnt_reg == CNT_LAST) begin
                    accept = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = ST_STABLE;
            end
        endcase

        // The press pulse is registered alongside the new stable level so the
        // consumer sees it in the cycle right after acceptance.
        if (accept) begin
            stable_next = sync_x;
            cnt_next    = '0;
            state_next  = ST_STABLE;
            press_next  = sync_x;
        end
    end

    assign stable = stable_reg;
    assign press  = press_reg;

endmodule : debounce_cell

// File: rtl/counter7sd_ctrl.sv
// -----------------------------------------------------------------------------
// counter7sd_ctrl
// Front-end control for the seven-segment counter: debounces the pause and
// reverse buttons into toggle-mode levels and generates a prescaled tick.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : counter7sd_ctrl_if.slave (btn_pause, btn_reverse in;
//           pause, reverse, tick out, all outputs registered)
// Build option:
//   COUNTER7SD_CTRL_LOCK_EN - when defined, reverse presses are ignored while
//   paused (pause = 0); otherwise reverse toggles regardless of pause.
// -----------------------------------------------------------------------------
module counter7sd_ctrl
    import counter7sd_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int TICK_DIV        = TICK_DIV_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    counter7sd_ctrl_if.slave      bus
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    // ------------------------------------------------------ button cells
    logic stable_pause, stable_reverse;
    logic press_pause,  press_reverse;

    debounce_cell #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_pause (
        .clock  (clock),
        .reset  (reset),
        .btn    (bus.btn_pause),
        .stable (stable_pause),
        .press  (press_pause)
    );

    debounce_cell #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_reverse (
        .clock  (clock),
        .reset  (reset),
        .btn    (bus.btn_reverse),
        .stable (stable_reverse),
        .press  (press_reverse)
    );

    // Only the press pulses drive the toggles; the debounced levels are kept
    // on the cell interface for other users and deliberately left unused here.
    logic unused_stable;
    assign unused_stable = stable_pause ^ stable_reverse;

    // ------------------------------------------------------ toggles
    logic pause_reg,   pause_next;
    logic reverse_reg, reverse_next;
    logic reverse_toggle;

`ifdef COUNTER7SD_CTRL_LOCK_EN
    // Direction may only change while the counter is running.
    assign reverse_toggle = press_reverse & pause_reg;
`else
    assign reverse_toggle = press_reverse;
`endif

    always_comb begin
        pause_next   = pause_reg   ^ press_pause;
        reverse_next = reverse_reg ^ reverse_toggle;
    end

    // ------------------------------------------------------ prescaler
    logic [PRE_W-1:0] pre_reg, pre_next;
    logic             tick_reg, tick_next;

    always_comb begin
        pre_next  = pre_reg;
        tick_next = 1'b0;
        // Freeze (not clear) while paused so resume keeps the phase.
        if (pause_reg) begin
            if (pre_reg == PRE_LAST) begin
                pre_next  = '0;
                tick_next = 1'b1;
            end else begin
                pre_next = pre_reg + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pause_reg   <= PAUSE_RST;
            reverse_reg <= REVERSE_RST;
            pre_reg     <= '0;
            tick_reg    <= 1'b0;
        end else begin
            pause_reg   <= pause_next;
            reverse_reg <= reverse_next;
            pre_reg     <= pre_next;
            tick_reg    <= tick_next;
        end
    end

    assign bus.pause   = pause_reg;
    assign bus.reverse = reverse_reg;
    assign bus.tick    = tick_reg;

endmodule : counter7sd_ctrl

// File: tb/tb_counter7sd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter7sd_ctrl
// Directed bench for counter7sd_ctrl with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// TICK_DIV=5. A held press changes its output on the 7th rising edge after
// the input is set; the tick fires every 5th edge while running.
// -----------------------------------------------------------------------------
module tb_counter7sd_ctrl;

    logic clock;
    logic reset;

    counter7sd_ctrl_if bus();

    counter7sd_ctrl #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .TICK_DIV        (5)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0d at %0t", tag, got, $time);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Wait (bounded) for a tick; on return the prescaler is at 0.
    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1);
            if (bus.tick) seen = 1'b1;
        end
        check_eq("tick_seen", seen, 1);
    endtask

    logic exp_lock_rev;

    initial begin
`ifdef COUNTER7SD_CTRL_LOCK_EN
        exp_lock_rev = 1'b0;
`else
        exp_lock_rev = 1'b1;
`endif
        reset           = 1'b0;
        bus.btn_pause   = 1'b0;
        bus.btn_reverse = 1'b0;

        // ---- reset state
        step(3);
        check_eq("rst_pause", bus.pause, 1);
        check_eq("rst_reverse", bus.reverse, 0);
        check_eq("rst_tick", bus.tick, 0);

        // ---- tick cadence from reset release: high after edges 5, 10, 15
        reset = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step(1);
            check_eq($sformatf("cadence_tick_%0d", k), bus.tick, (k % 5 == 0) ? 1 : 0);
        end

        // ---- clean press on pause, landing the pause edge at prescaler=2
        wait_tick();
        bus.btn_pause = 1'b1;
        step(6);
        check_eq("press1_before", bus.pause, 1);
        step(1);
        check_eq("press1_edge7", bus.pause, 0);
        for (int k = 0; k < 5; k++) begin
            step(1);
            check_eq("paused_tick", bus.tick, 0);
        end
        bus.btn_pause = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            check_eq("release_tick", bus.tick, 0);
        end
        check_eq("release_pause", bus.pause, 0);

        // ---- second press resumes; held prescaler 2 -> 3 -> 4 -> wrap
        bus.btn_pause = 1'b1;
        step(6);
        check_eq("press2_before", bus.pause, 0);
        check_eq("press2_before_tick", bus.tick, 0);
        step(1);
        check_eq("press2_edge7", bus.pause, 1);
        step(1);
        check_eq("resume_tick_pre3", bus.tick, 0);
        step(1);
        check_eq("resume_tick_pre4", bus.tick, 0);
        step(1);
        check_eq("resume_tick_wrap", bus.tick, 1);
        step(1);
        check_eq("resume_tick_after", bus.tick, 0);
        bus.btn_pause = 1'b0;
        step(10);
        check_eq("hold_pause", bus.pause, 1);

        // ---- bounce on reverse: 2 high / 2 low for 20 cycles, then held
        for (int k = 0; k < 5; k++) begin
            bus.btn_reverse = 1'b1;
            step(2);
            check_eq("bounce_hi", bus.reverse, 0);
            bus.btn_reverse = 1'b0;
            step(2);
            check_eq("bounce_lo", bus.reverse, 0);
        end
        bus.btn_reverse = 1'b1;
        step(6);
        check_eq("bounce_before", bus.reverse, 0);
        step(1);
        check_eq("bounce_edge7", bus.reverse, 1);
        step(5);
        bus.btn_reverse = 1'b0;
        step(10);
        check_eq("bounce_hold", bus.reverse, 1);

        // ---- simultaneous press: pause 1->0, reverse 1->0 on the same edge
        bus.btn_pause   = 1'b1;
        bus.btn_reverse = 1'b1;
        step(6);
        check_eq("simul_before_p", bus.pause, 1);
        check_eq("simul_before_r", bus.reverse, 1);
        step(1);
        check_eq("simul_pause", bus.pause, 0);
        check_eq("simul_reverse", bus.reverse, 0);
        bus.btn_pause   = 1'b0;
        bus.btn_reverse = 1'b0;
        step(10);

        // ---- reverse press while paused
        bus.btn_reverse = 1'b1;
        step(7);
        check_eq("lock_reverse", bus.reverse, exp_lock_rev);
        check_eq("lock_pause", bus.pause, 0);
        bus.btn_reverse = 1'b0;
        step(10);

        // ---- resume
        bus.btn_pause = 1'b1;
        step(7);
        check_eq("resume_pause", bus.pause, 1);
        bus.btn_pause = 1'b0;
        step(10);

        // ---- asynchronous reset at prescaler=3, between edges
        wait_tick();
        step(3);
        #3 reset = 1'b0;
        #1;
        check_eq("async_rst_pause", bus.pause, 1);
        check_eq("async_rst_reverse", bus.reverse, 0);
        check_eq("async_rst_tick", bus.tick, 0);
        step(2);
        check_eq("rst_held_tick", bus.tick, 0);

        // ---- release with pause held: first tick after 5 edges, press at 7
        bus.btn_pause = 1'b1;
        reset         = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            check_eq($sformatf("post_rst_tick_%0d", k), bus.tick, (k == 5) ? 1 : 0);
        end
        step(1);
        check_eq("held_btn_edge6", bus.pause, 1);
        step(1);
        check_eq("held_btn_edge7", bus.pause, 0);
        bus.btn_pause = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_counter7sd_ctrl
